// File: rtl/counter_preset_seq_if.sv
// Command channel for the preset/count sequencer.
// Master offers a command, slave raises ready when idle.
interface counter_preset_seq_if #(
  parameter int TICK_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_preset;
  logic [TICK_W-1:0] cmd_ticks;

  modport master (
    output cmd_valid,
    output cmd_preset,
    output cmd_ticks,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_preset,
    input  cmd_ticks,
    output cmd_ready
  );
endinterface

// File: rtl/counter_preset_seq.sv
// Sequencer that loads a 4-bit counter, then issues a
// run of count enables, and tallies carry-outs seen.
module counter_preset_seq #(
  parameter int TICK_W = 8
) (
  input  logic       clk,
  input  logic       clear,
  counter_preset_seq_if.slave cmd,
  input  logic       abort,
  input  logic       c_in,
  output logic [3:0] data_in,
  output logic       load,
  output logic       count,
  output logic       done,
  output logic [3:0] wraps
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        preset_q;
  logic [TICK_W-1:0] remaining_q;
  logic [3:0]        acc_q;
  logic [3:0]        acc_d;
  logic [3:0]        wraps_q;
  logic              accept;
  logic              last_tick;

  assign accept    = (state_q == IDLE) && cmd.cmd_valid;
  assign last_tick = (remaining_q == TICK_W'(1));

  // State register
  always_ff @(posedge clk or posedge clear) begin
    if (clear) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; abort only bites in LOAD and RUN
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) state_d = LOAD;
      end
      LOAD: begin
        if (abort)
          state_d = IDLE;
        else if (remaining_q != '0)
          state_d = RUN;
        else
          state_d = DONE;
      end
      RUN: begin
        if (abort)          state_d = IDLE;
        else if (last_tick) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Carry tally for this command, saturating at 15
  always_comb begin
    acc_d = acc_q;
    if (state_q == RUN && c_in && acc_q != 4'hF)
      acc_d = acc_q + 4'd1;
  end

  // Command latch and tick down-counter
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      preset_q    <= '0;
      remaining_q <= '0;
    end else if (accept) begin
      preset_q    <= cmd.cmd_preset;
      remaining_q <= cmd.cmd_ticks;
    end else if (state_q == RUN) begin
      remaining_q <= remaining_q - TICK_W'(1);
    end
  end

  // Accumulator restarts on every accepted command
  always_ff @(posedge clk or posedge clear) begin
    if (clear)       acc_q <= '0;
    else if (accept) acc_q <= '0;
    else             acc_q <= acc_d;
  end

  // Publish the tally only when a command completes;
  // the final RUN cycle's carry is folded in via acc_d
  always_ff @(posedge clk or posedge clear) begin
    if (clear)
      wraps_q <= '0;
    else if (state_d == DONE && state_q != DONE)
      wraps_q <= acc_d;
  end

  // Moore outputs
  always_comb begin
    cmd.cmd_ready = 1'b0;
    load          = 1'b0;
    count         = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      IDLE:    cmd.cmd_ready = 1'b1;
      LOAD:    load          = 1'b1;
      RUN:     count         = 1'b1;
      DONE:    done          = 1'b1;
      default: cmd.cmd_ready = 1'b1;
    endcase
  end

  assign data_in = preset_q;
  assign wraps   = wraps_q;

endmodule
